// File: rtl/alu_pkg.sv
// Opcode constants and FSM state type shared by the sequential N-bit ALU,
// its handshake interface users and the iterative multiplier.
package alu_pkg;

   // Opcodes are {ainv, binv, select[1:0]}
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b0011;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/nbit_alu_seq_if.sv
// Operand/result channel of the sequential ALU: one valid/ready handshake in,
// one valid/ready handshake out.
interface nbit_alu_seq_if #(parameter int N = 32);

   // A transfer happens on a rising edge where valid && ready; the sender holds
   // its payload stable and keeps valid high until that edge, ready may toggle freely.
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         zero;
   logic         carry;
   logic         overflow;
   logic         negative;
   logic         err;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow, negative, err
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow, negative, err
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier: one partial product per cycle, N cycles per
// operation; product shows the final value combinationally while done is high.
module alu_mul_iter #(parameter int N = 32) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic           busy;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   mcand;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] acc_next;
   logic [N:0]     upper;

   // Multiplier bits sit in the low half and are consumed LSB first as acc shifts right
   always_comb begin
      upper    = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_next = {upper, acc[N-1:1]};
   end

   assign done    = busy && (cnt == LAST);
   assign product = acc_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy  <= 1'b0;
         cnt   <= '0;
         mcand <= '0;
         acc   <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= '0;
         mcand <= a;
         acc   <= {{N{1'b0}}, b};
      end else if (busy) begin
         acc <= acc_next;
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/nbit_alu_seq.sv
// Registered N-bit ALU with valid/ready on both sides and a single-entry output
// buffer. Define ALU_MUL_EN to build in the iterative multiplier (opcode 0011).
module nbit_alu_seq
   import alu_pkg::*;
#(parameter int N = 32) (
   input  logic           clk,
   input  logic           rst,
   nbit_alu_seq_if.slave  bus,
   output state_t         dbg_state
);

   logic         accept, idle;
   logic         is_sub, cout, add_ovf;
   logic [N-1:0] b_eff, sum;
   logic [N-1:0] alu_res;
   logic         alu_c, alu_v, alu_err;
   logic         ld_en, ld_c, ld_v, ld_err;
   logic [N-1:0] ld_res;
   logic         ov_q, z_q, c_q, v_q, n_q, err_q;
   logic [N-1:0] res_q;

   assign bus.in_ready = idle && (!ov_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // SUB and SLT share the adder as a + ~b + 1
   always_comb begin
      is_sub        = (bus.op == OP_SUB) || (bus.op == OP_SLT);
      b_eff         = is_sub ? ~bus.b : bus.b;
      {cout, sum}   = {1'b0, bus.a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
      add_ovf       = (bus.a[N-1] == b_eff[N-1]) && (sum[N-1] != bus.a[N-1]);
      alu_res       = '0;
      alu_c         = 1'b0;
      alu_v         = 1'b0;
      alu_err       = 1'b0;
      case (bus.op)
         OP_AND: alu_res = bus.a & bus.b;
         OP_OR:  alu_res = bus.a | bus.b;
         OP_NOR: alu_res = ~(bus.a | bus.b);
         OP_ADD, OP_SUB: begin
            alu_res = sum;
            alu_c   = cout;
            alu_v   = add_ovf;
         end
         OP_SLT: begin
            alu_res = {{(N-1){1'b0}}, sum[N-1] ^ add_ovf};
            alu_c   = cout;
            alu_v   = add_ovf;
         end
         default: alu_err = 1'b1;
      endcase
   end

`ifdef ALU_MUL_EN
   state_t         state, state_next;
   logic           is_mul, mul_start, mul_done;
   logic [2*N-1:0] product;

   assign is_mul    = (bus.op == OP_MUL);
   assign mul_start = accept && is_mul;
   assign idle      = (state == ST_IDLE);
   assign dbg_state = state;

   alu_mul_iter #(.N(N)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (mul_start) state_next = ST_MUL;
         ST_MUL:  if (mul_done)  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ld_en  = accept && !is_mul;
      ld_res = alu_res;
      ld_c   = alu_c;
      ld_v   = alu_v;
      ld_err = alu_err;
      if (mul_done) begin
         ld_en  = 1'b1;
         ld_res = product[N-1:0];
         ld_c   = 1'b0;
         ld_v   = |product[2*N-1:N];
         ld_err = 1'b0;
      end
   end
`else
   assign idle      = 1'b1;
   assign dbg_state = ST_IDLE;

   always_comb begin
      ld_en  = accept;
      ld_res = alu_res;
      ld_c   = alu_c;
      ld_v   = alu_v;
      ld_err = alu_err;
   end
`endif

   // Illegal opcodes report all flags low, so zero is masked by err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_q  <= 1'b0;
         res_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
         n_q   <= 1'b0;
         err_q <= 1'b0;
      end else if (ld_en) begin
         ov_q  <= 1'b1;
         res_q <= ld_res;
         z_q   <= (ld_res == '0) && !ld_err;
         c_q   <= ld_c;
         v_q   <= ld_v;
         n_q   <= ld_res[N-1];
         err_q <= ld_err;
      end else if (bus.out_ready) begin
         ov_q  <= 1'b0;
      end
   end

   assign bus.out_valid = ov_q;
   assign bus.result    = res_q;
   assign bus.zero      = z_q;
   assign bus.carry     = c_q;
   assign bus.overflow  = v_q;
   assign bus.negative  = n_q;
   assign bus.err       = err_q;

endmodule

// File: doc/nbit_alu_seq.md
# nbit_alu_seq

Parametrised, registered N-bit ALU with a valid/ready handshake on input and output, a full flag set (zero, carry, overflow, negative), and an optional iterative multiplier. It succeeds the combinational ripple ALU as the datapath execute unit, so the datapath can stall on backpressure and absorb multi-cycle operations without combinational paths from operands to result consumers.

## Interface
- N, 32: operand and result width, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  N  operand A.
- b  in  N  operand B.
- op  in  4  opcode, encoded {ainv, binv, select[1:0]}.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  N  registered result.
- zero, carry, overflow, negative  out  1 each  registered flags.
- err  out  1  illegal opcode flag, registered with the result.

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB, computed as a + ~b + 1.
  - 0111 SLT: signed less-than; result is {N-1 zeros, lt}, where lt = sum[N-1] XOR overflow of the SUB.
  - 1100 NOR.
  - 0011 MUL: only with the multiplier compiled in (see Configuration).
  - Any other code: result 0, all flags 0, err=1.
- Flags:
  - zero = (result == 0); negative = result[N-1]. Both apply to every opcode.
  - carry = carry-out of bit N-1 for ADD, SUB and SLT. For SUB, carry=1 means no borrow. carry is 0 for all other ops.
  - overflow = signed overflow for ADD, SUB and SLT. For MUL, overflow = (upper N bits of the 2N-bit unsigned product are nonzero). overflow is 0 otherwise.
  - MUL result = lower N bits of the unsigned product.
- FSM states:
  - IDLE: accepts a new operation.
  - MUL: iterating the multiply.
  - Transitions: IDLE -> MUL on accepting a MUL; MUL -> IDLE when the iteration counter reaches N-1, loading the output register on that edge.
- Output register: a single-entry buffer. Contents are held stable while out_valid && !out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Simultaneous consume and accept (non-MUL op): out_valid stays 1 and the output register loads the new result on that edge.
- Accepting a MUL while the old result is consumed: out_valid falls to 0 on that edge.

## Timing
- Reset values: state=IDLE, out_valid=0, result=0, all flags=0, err=0, counter=0. in_ready=1 once reset is released.
- Non-MUL ops: out_valid is 1 on the cycle after the accepting edge (latency 1). Throughput is 1 per cycle under continuous out_ready.
- MUL: out_valid rises N cycles after the accepting edge. in_ready=0 for the whole of the MUL state.
- Reset asserted mid-MUL: the operation is discarded and all outputs return to their reset values immediately (asynchronous). No result is emitted after reset releases.
- a, b and op are sampled only on the accepting edge. Changes at any other time have no effect.

## Configuration
- ALU_MUL_EN defined: the MUL opcode and MUL state are implemented as described above.
- ALU_MUL_EN undefined: 0011 is treated as an illegal opcode (result 0, err=1, latency 1). The MUL state and the multiplier logic are absent.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL);
  - the FSM state typedef.
- Sub-module alu_mul_iter: shift-add multiplier with start/done signals, a log2(N)-bit counter and a 2N-bit accumulator. It is instantiated only under ALU_MUL_EN.
- All single-cycle ops are combinational logic in the top module, feeding the output register.

## Test plan
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, negative=1, carry=0, zero=0; out_valid one cycle after accept.
- SUB a=5, b=5 -> result 0, zero=1, carry=1. SLT a=0x80000000, b=1 -> result 1. SLT a=0x7FFFFFFF, b=0xFFFFFFFF -> result 0.
- Hold out_ready=0 for 3 cycles after an ADD result:
  - result and flags stay stable and in_ready=0;
  - raise out_ready with in_valid=1 -> new op accepted on the same edge and out_valid stays 1.
- With ALU_MUL_EN: MUL 7×6 -> result 42, overflow=0, out_valid exactly 32 cycles after accept. MUL 0x10000×0x10000 -> result 0, zero=1, overflow=1.
- op=1111 -> result 0, err=1, all flags 0. Without ALU_MUL_EN, op=0011 -> err=1 with latency 1.
- Assert rst at cycle 10 of a MUL -> out_valid=0 and state IDLE immediately. After release, in_ready=1 and no spurious out_valid.
